fifo_uart_tx: RTL
=================

# fifo_uart_tx

Drains words from the upstream FIFO and transmits them as back-to-back 8N1 UART frames, one byte at a time, least-significant byte first. It connects directly to the FIFO read side (`r_en`/`r_ready`/`dataR`) and pops one word only when the serial line is free. A word is therefore never lost or duplicated, and the FIFO provides all buffering.

## Interface
Parameters:
- `DataDepth`, 32: FIFO word width in bits. Must be a multiple of 8. Bytes per word is `DataDepth/8`.
- `ClkPerBit`, 16: clock cycles per UART bit. Must be ≥ 2.
- `ReadLatency`, 1: cycles from the pop cycle until `dataR` holds the popped word. Legal values are 0 and 1.

Ports:
- `clk`, in, 1: sole clock. All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset. Low forces the reset state immediately. Release is sampled on `clk`.
- `tx_en`, in, 1: permits starting a new word. Sampled only in IDLE.
- `r_ready`, in, 1: FIFO non-empty.
- `r_en`, out, 1: pop strobe to the FIFO. Registered, and high for exactly one cycle per word.
- `dataR`, in, `DataDepth`: FIFO read data.
- `tx`, out, 1: serial line. Idle level is 1. Registered.
- `busy`, out, 1: high in every state except IDLE.
- `byte_idx`, out, `$clog2(DataDepth/8)` (minimum 1 bit): index of the byte currently on the line. It is 0 outside DATA-phase states.

## Operation
- States: IDLE, POP, WAIT, START, DATA, STOP.
- IDLE → POP when `tx_en && r_ready`.
- POP:
  - `r_en=1` for this single cycle.
  - If `ReadLatency==0`, capture `dataR` into `shreg` at the end of POP and go to START.
  - Otherwise go to WAIT.
- WAIT: one cycle. Capture `dataR` into `shreg` at the end of WAIT, then go to START.
- START: `tx=0` for `ClkPerBit` cycles. `bitcnt` is cleared on entry.
- DATA:
  - 8 bits are sent, each held `ClkPerBit` cycles.
  - The bit sent is `shreg[0]`, so each byte goes out LSB first.
  - `shreg` shifts right by 1 at the end of each bit period.
- STOP:
  - `tx=1` for `ClkPerBit` cycles.
  - If `byte_idx < DataDepth/8-1`: increment `byte_idx` and go to START, with no idle gap.
  - Otherwise clear `byte_idx` and go to IDLE.
- Counters:
  - `baudcnt` is `$clog2(ClkPerBit)` bits wide. It counts 0..`ClkPerBit-1` and wraps to 0 at each bit boundary.
  - `bitcnt` is 3 bits and counts 0..7.
  - No other arithmetic is performed.
- `tx_en` is only sampled in IDLE. Dropping it mid-word does not abort the word: the current word completes and no further pop occurs.
- `r_ready` is ignored outside IDLE. A pop is issued only when `r_ready` was high in the preceding IDLE cycle, so the FIFO's own gating never suppresses it.
- FIFO empty in IDLE: the block stays in IDLE with `tx=1` and `r_en=0` indefinitely.
- FIFO non-empty after STOP:
  - The block spends exactly one IDLE cycle, then pops again.
  - Line gap between consecutive words = 1 (IDLE) + 1 (POP) + `ReadLatency` cycles at `tx=1`.
- Reset (`rst`=0), at any time including mid-frame:
  - State returns to IDLE.
  - `tx=1`, `r_en=0`, `busy=0`, `byte_idx=0`. `shreg`, `baudcnt` and `bitcnt` are cleared.
  - A partially sent word is discarded; it is not re-popped.

## Timing
- The IDLE decision is made at edge n. `r_en` is high during cycle n+1 (POP).
- The start bit begins:
  - at cycle n+2 when `ReadLatency=0`;
  - at cycle n+3 when `ReadLatency=1`.
- Word duration from start of the first start bit to end of the last stop bit: `(DataDepth/8)*10*ClkPerBit` cycles. With the defaults this is 640.
- `busy` rises in the POP cycle and falls on the first IDLE cycle.
- `tx` transitions occur only on bit boundaries, so each level is held exactly `ClkPerBit` cycles.

## Test plan
All scenarios use `DataDepth=32`, `ClkPerBit=4`, `ReadLatency=1` unless stated otherwise.

- **Single word:** FIFO holds 0xA53C0F81 and `tx_en=1`.
  - Exactly one `r_en` pulse.
  - `tx` carries four frames with bytes 0x81, 0x0F, 0x3C, 0xA5.
  - First frame bit sequence: 0,1,0,0,0,0,0,0,1,1, each held 4 cycles.
  - `busy` is high for 2 + 160 cycles.
- **Back-to-back words:** FIFO holds 0x00000000 and 0xFFFFFFFF.
  - Exactly 2 pulses on `r_en`.
  - The gap between the last stop bit of word 1 and the start bit of word 2 is 3 cycles at `tx=1`.
- **Empty FIFO:** `r_ready=0` for 100 cycles with `tx_en=1`.
  - `r_en` never asserts; `tx=1` and `busy=0` throughout.
- **`tx_en` drop mid-word:** deassert `tx_en` during byte 2 with 2 words queued.
  - The first word completes all 40 bits.
  - No second `r_en`; the block returns to IDLE.
- **Reset mid-frame:** pull `rst` low during DATA of byte 1.
  - `tx=1`, `busy=0`, `r_en=0` immediately, without waiting for an edge.
  - After release with 1 word queued, the next frame starts with byte 0 of the next FIFO word.
- **`ReadLatency=0`:** FIFO holds 0x12345678.
  - The start bit begins at cycle n+2.
  - Bytes 0x78, 0x56, 0x34, 0x12 are sent in that order.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side bundle: pop strobe from the transmitter, non-empty flag and read data from the FIFO.
// The transmitter uses the master modport and the FIFO side uses the slave modport.
interface fifo_uart_tx_if #(
    parameter int DataDepth = 32
);
    logic                 r_en;
    logic                 r_ready;
    logic [DataDepth-1:0] dataR;

    modport master (output r_en, input r_ready, input dataR);
    modport slave  (input r_en, output r_ready, output dataR);
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops FIFO words and sends them as 8N1 frames, LSB byte first; start bit 2+ReadLatency cycles after the IDLE decision.
// Pops only from IDLE while tx_en is high and the FIFO is non-empty; all buffering stays in the FIFO.
module fifo_uart_tx #(
    parameter int DataDepth   = 32,
    parameter int ClkPerBit   = 16,
    parameter int ReadLatency = 1,
    localparam int NBytes     = DataDepth / 8,
    localparam int IdxW       = (NBytes > 1) ? $clog2(NBytes) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tx_en,
    fifo_uart_tx_if.master  rd,
    output logic            tx,
    output logic            busy,
    output logic [IdxW-1:0] byte_idx
);
    localparam int              BaudW    = $clog2(ClkPerBit);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(ClkPerBit - 1);
    localparam logic [IdxW-1:0]  ByteLast = IdxW'(NBytes - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_WAIT, S_START, S_DATA, S_STOP
    } state_t;

    state_t               state_q;
    logic [DataDepth-1:0] shreg_q;
    logic [BaudW-1:0]     baud_q;
    logic [2:0]           bit_q;
    logic [IdxW-1:0]      byte_q;
    logic                 tx_q;
    logic                 r_en_q;
    logic                 bit_end;

    assign bit_end = (baud_q == BaudLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= 1'b1;
            r_en_q  <= 1'b0;
        end else begin
            r_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tx_en && rd.r_ready) begin
                        state_q <= S_POP;
                        r_en_q  <= 1'b1;
                    end
                end
                S_POP: begin
                    // Zero-latency FIFOs present the popped word during the pop cycle itself.
                    if (ReadLatency == 0) begin
                        shreg_q <= rd.dataR;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        baud_q  <= '0;
                        bit_q   <= '0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    shreg_q <= rd.dataR;
                    state_q <= S_START;
                    tx_q    <= 1'b0;
                    baud_q  <= '0;
                    bit_q   <= '0;
                end
                S_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shreg_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        shreg_q <= shreg_q >> 1;
                        if (bit_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shreg_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        // The shift register already holds the next byte in its low bits.
                        if (byte_q < ByteLast) begin
                            byte_q  <= byte_q + 1'b1;
                            state_q <= S_START;
                            tx_q    <= 1'b0;
                            bit_q   <= '0;
                        end else begin
                            byte_q  <= '0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign rd.r_en  = r_en_q;
    assign busy     = (state_q != S_IDLE);
    assign byte_idx = byte_q;
endmodule
